// File: rtl/vidclk_switch_seq.sv
// Video PLL retune sequencer: blanks the pixel domain, switches vidmode, waits for re-lock and settle.
// Optional switch_done pulse output is built when VIDCLK_SWITCH_DONE_EN is defined.
module vidclk_switch_seq #(
  parameter int BLANK_CYCLES  = 64,
  parameter int UNLOCK_WAIT   = 16,
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 2000000
) (
  input  logic clk_28m,
  input  logic reset_n,
  input  logic req_mode,
  input  logic video_locked,
  output logic vidmode,
  output logic video_reset_n,
  output logic busy,
  output logic cur_mode,
`ifdef VIDCLK_SWITCH_DONE_EN
  output logic switch_done,
`endif
  output logic lock_fail
);

  // A zero parameter behaves as one cycle; each counter only needs to reach N-1.
  localparam int BLANK_N   = (BLANK_CYCLES  < 1) ? 1 : BLANK_CYCLES;
  localparam int UNLOCK_N  = (UNLOCK_WAIT   < 1) ? 1 : UNLOCK_WAIT;
  localparam int SETTLE_N  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int TIMEOUT_N = (LOCK_TIMEOUT  < 1) ? 1 : LOCK_TIMEOUT;

  localparam int BLANK_W   = (BLANK_N   > 1) ? $clog2(BLANK_N)   : 1;
  localparam int UNLOCK_W  = (UNLOCK_N  > 1) ? $clog2(UNLOCK_N)  : 1;
  localparam int SETTLE_W  = (SETTLE_N  > 1) ? $clog2(SETTLE_N)  : 1;
  localparam int TIMEOUT_W = (TIMEOUT_N > 1) ? $clog2(TIMEOUT_N) : 1;

  localparam logic [BLANK_W-1:0]   BLANK_LAST   = BLANK_W'(BLANK_N - 1);
  localparam logic [UNLOCK_W-1:0]  UNLOCK_LAST  = UNLOCK_W'(UNLOCK_N - 1);
  localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_N - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_N - 1);

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_BLANK     = 3'd1,
    ST_SWITCH    = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_SETTLE    = 3'd4
  } state_t;

  state_t                state_reg, state_next;
  logic [1:0]            sync_reg;
  logic                  lk;
  logic [BLANK_W-1:0]    blank_cnt_reg, blank_cnt_next;
  logic [UNLOCK_W-1:0]   unlock_cnt_reg, unlock_cnt_next;
  logic [SETTLE_W-1:0]   settle_cnt_reg, settle_cnt_next;
  logic [TIMEOUT_W-1:0]  timeout_cnt_reg, timeout_cnt_next;
  logic                  vidmode_reg, vidmode_next;
  logic                  video_reset_n_reg, video_reset_n_next;
  logic                  busy_reg, busy_next;
  logic                  cur_mode_reg, cur_mode_next;
  logic                  lock_fail_reg, lock_fail_next;
`ifdef VIDCLK_SWITCH_DONE_EN
  logic                  switch_done_reg, switch_done_next;
`endif

  // video_locked comes from the PLL's own domain.
  always_ff @(posedge clk_28m or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], video_locked};
    end
  end
  assign lk = sync_reg[1];

  always_ff @(posedge clk_28m or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= ST_WAIT_LOCK;
      blank_cnt_reg     <= '0;
      unlock_cnt_reg    <= '0;
      settle_cnt_reg    <= '0;
      timeout_cnt_reg   <= '0;
      vidmode_reg       <= 1'b1;
      video_reset_n_reg <= 1'b0;
      busy_reg          <= 1'b1;
      cur_mode_reg      <= 1'b1;
      lock_fail_reg     <= 1'b0;
`ifdef VIDCLK_SWITCH_DONE_EN
      switch_done_reg   <= 1'b0;
`endif
    end else begin
      state_reg         <= state_next;
      blank_cnt_reg     <= blank_cnt_next;
      unlock_cnt_reg    <= unlock_cnt_next;
      settle_cnt_reg    <= settle_cnt_next;
      timeout_cnt_reg   <= timeout_cnt_next;
      vidmode_reg       <= vidmode_next;
      video_reset_n_reg <= video_reset_n_next;
      busy_reg          <= busy_next;
      cur_mode_reg      <= cur_mode_next;
      lock_fail_reg     <= lock_fail_next;
`ifdef VIDCLK_SWITCH_DONE_EN
      switch_done_reg   <= switch_done_next;
`endif
    end
  end

  // Counters run only in their own state and stop at N-1, so every state is entered with a zero count.
  always_comb begin
    state_next       = state_reg;
    blank_cnt_next   = '0;
    unlock_cnt_next  = '0;
    settle_cnt_next  = '0;
    timeout_cnt_next = '0;
    case (state_reg)
      ST_RUN: begin
        if (req_mode != vidmode_reg) begin
          state_next = ST_BLANK;
        end else if (!lk) begin
          state_next = ST_WAIT_LOCK;
        end
      end
      ST_BLANK: begin
        if (blank_cnt_reg == BLANK_LAST) begin
          state_next = ST_SWITCH;
        end else begin
          blank_cnt_next = blank_cnt_reg + 1'b1;
        end
      end
      ST_SWITCH: begin
        if (unlock_cnt_reg == UNLOCK_LAST) begin
          state_next = ST_WAIT_LOCK;
        end else begin
          unlock_cnt_next = unlock_cnt_reg + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (lk) begin
          state_next = ST_SETTLE;
        end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
          state_next = ST_BLANK;
        end else begin
          timeout_cnt_next = timeout_cnt_reg + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!lk) begin
          state_next = ST_WAIT_LOCK;
        end else if (settle_cnt_reg == SETTLE_LAST) begin
          state_next = ST_RUN;
        end else begin
          settle_cnt_next = settle_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_WAIT_LOCK;
      end
    endcase
  end

  // Outputs are computed from the upcoming state so the registers line up with it.
  always_comb begin
    vidmode_next       = vidmode_reg;
    cur_mode_next      = cur_mode_reg;
    lock_fail_next     = lock_fail_reg;
    video_reset_n_next = (state_next == ST_RUN);
    busy_next          = (state_next != ST_RUN);
`ifdef VIDCLK_SWITCH_DONE_EN
    switch_done_next   = 1'b0;
`endif
    if ((state_reg == ST_BLANK) && (state_next == ST_SWITCH)) begin
      vidmode_next = req_mode;
    end
    if ((state_reg == ST_WAIT_LOCK) && (state_next == ST_BLANK)) begin
      lock_fail_next = 1'b1;
    end
    if ((state_reg == ST_SETTLE) && (state_next == ST_RUN)) begin
      cur_mode_next  = vidmode_reg;
      lock_fail_next = 1'b0;
`ifdef VIDCLK_SWITCH_DONE_EN
      switch_done_next = (vidmode_reg != cur_mode_reg);
`endif
    end
  end

  assign vidmode       = vidmode_reg;
  assign video_reset_n = video_reset_n_reg;
  assign busy          = busy_reg;
  assign cur_mode      = cur_mode_reg;
  assign lock_fail     = lock_fail_reg;
`ifdef VIDCLK_SWITCH_DONE_EN
  assign switch_done   = switch_done_reg;
`endif

endmodule

// File: tb/tb_vidclk_switch_seq.sv
// Directed bench for vidclk_switch_seq: expectations are queued as stimulus is applied and
// compared when the DUT responds. Define VIDCLK_SWITCH_DONE_EN to also check switch_done.
`timescale 1ns/1ps
module tb_vidclk_switch_seq;

  localparam int BLANK    = 4;
  localparam int UNLOCK   = 4;
  localparam int SETTLE   = 8;
  localparam int TIMEOUT  = 100;
  localparam int SYNC_LAT = 2;
  // Raising video_locked to release: synchroniser, one WAIT_LOCK decision, then settle.
  localparam int LOCK_TO_RUN = SYNC_LAT + 1 + SETTLE;
  localparam int GLITCH_AT   = 5;

  localparam int S_VRST     = 0;
  localparam int S_VIDMODE  = 1;
  localparam int S_LOCKFAIL = 2;

  logic clk_28m      = 1'b0;
  logic reset_n      = 1'b0;
  logic req_mode     = 1'b1;
  logic video_locked = 1'b1;
  logic vidmode, video_reset_n, busy, cur_mode, lock_fail;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

`ifdef VIDCLK_SWITCH_DONE_EN
  logic switch_done;
  int   sd_pulses = 0;
  always @(negedge clk_28m) begin
    if (reset_n && (switch_done === 1'b1)) sd_pulses++;
  end
`endif

  vidclk_switch_seq #(
    .BLANK_CYCLES (BLANK),
    .UNLOCK_WAIT  (UNLOCK),
    .SETTLE_CYCLES(SETTLE),
    .LOCK_TIMEOUT (TIMEOUT)
  ) dut (
    .clk_28m      (clk_28m),
    .reset_n      (reset_n),
    .req_mode     (req_mode),
    .video_locked (video_locked),
    .vidmode      (vidmode),
    .video_reset_n(video_reset_n),
    .busy         (busy),
    .cur_mode     (cur_mode),
`ifdef VIDCLK_SWITCH_DONE_EN
    .switch_done  (switch_done),
`endif
    .lock_fail    (lock_fail)
  );

  always #5 clk_28m = ~clk_28m;

  task automatic tick();
    @(posedge clk_28m);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0d with no expectation queued", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      S_VRST:     return video_reset_n;
      S_VIDMODE:  return vidmode;
      default:    return lock_fail;
    endcase
  endfunction

  // Cycles until the selected output reaches level; -1 if the budget runs out.
  task automatic wait_for(input int sel, input logic level, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (sig(sel) === level) return;
    end
    n = -1;
  endtask

  initial begin
    int n;
    int n_high;
    int sd_before;
    sd_before = 0;

    // Reset values
    repeat (3) tick();
    push("rst_video_reset_n", 0); pop_check(video_reset_n);
    push("rst_busy", 1);          pop_check(busy);
    push("rst_vidmode", 1);       pop_check(vidmode);
    push("rst_cur_mode", 1);      pop_check(cur_mode);
    push("rst_lock_fail", 0);     pop_check(lock_fail);
`ifdef VIDCLK_SWITCH_DONE_EN
    push("rst_switch_done", 0);   pop_check(switch_done);
`endif

    // Power-up with lock already present
    reset_n = 1'b1;
    push("pwrup_release_cycles", LOCK_TO_RUN);
    wait_for(S_VRST, 1'b1, 300, n); pop_check(n);
    push("pwrup_busy", 0);      pop_check(busy);
    push("pwrup_cur_mode", 1);  pop_check(cur_mode);
    push("pwrup_vidmode", 1);   pop_check(vidmode);
    push("pwrup_lock_fail", 0); pop_check(lock_fail);

    // Mode switch to 56 MHz with PLL unlock/relock
`ifdef VIDCLK_SWITCH_DONE_EN
    sd_before = sd_pulses;
`endif
    req_mode = 1'b0;
    push("sw_blank_vrst", 0);
    push("sw_blank_vidmode_held", 1);
    tick();
    pop_check(video_reset_n);
    pop_check(vidmode);
    push("sw_vidmode_fall_cycles", BLANK);
    wait_for(S_VIDMODE, 1'b0, 300, n); pop_check(n);
    repeat (2) tick();
    video_locked = 1'b0;
    repeat (20) tick();
    push("sw_unlocked_vrst", 0); pop_check(video_reset_n);
    video_locked = 1'b1;
    push("sw_lock_to_run_cycles", LOCK_TO_RUN);
    wait_for(S_VRST, 1'b1, 300, n); pop_check(n);
    push("sw_cur_mode", 0); pop_check(cur_mode);
    push("sw_busy", 0);     pop_check(busy);
    tick();
`ifdef VIDCLK_SWITCH_DONE_EN
    push("sw_done_pulses", 1); pop_check(32'(sd_pulses - sd_before));
`endif

    // Lock timeout with video_locked stuck low
    video_locked = 1'b0;
    push("to_lockloss_cycles", SYNC_LAT + 1);
    wait_for(S_VRST, 1'b0, 300, n); pop_check(n);
    push("to_lock_fail_cycles", TIMEOUT);
    wait_for(S_LOCKFAIL, 1'b1, 300, n); pop_check(n);
    n_high = 0;
    repeat (30) begin
      tick();
      if (video_reset_n !== 1'b0) n_high++;
    end
    push("to_vrst_high_cycles", 0); pop_check(n_high);
    push("to_busy", 1);             pop_check(busy);
    push("to_vidmode_retry", 0);    pop_check(vidmode);
    push("to_lock_fail_sticky", 1); pop_check(lock_fail);
    video_locked = 1'b1;
    push("to_recover_cycles", LOCK_TO_RUN);
    wait_for(S_VRST, 1'b1, 300, n); pop_check(n);
    push("to_lock_fail_cleared", 0); pop_check(lock_fail);

    // One-cycle lock glitch at settle count GLITCH_AT restarts the settle window
    video_locked = 1'b0;
    push("gl_lockloss_cycles", SYNC_LAT + 1);
    wait_for(S_VRST, 1'b0, 300, n); pop_check(n);
    repeat (3) tick();
    video_locked = 1'b1;
    repeat (SYNC_LAT + 1 + GLITCH_AT - 2) tick();
    video_locked = 1'b0;
    tick();
    video_locked = 1'b1;
    push("gl_release_from_raise", SYNC_LAT + 1 + GLITCH_AT + 1 + 1 + SETTLE);
    wait_for(S_VRST, 1'b1, 300, n);
    pop_check((n < 0) ? n : n + SYNC_LAT + 1 + GLITCH_AT - 1);

    // Short lock loss in RUN: recovers without a mode change
`ifdef VIDCLK_SWITCH_DONE_EN
    sd_before = sd_pulses;
`endif
    video_locked = 1'b0;
    repeat (3) tick();
    video_locked = 1'b1;
    push("ll_vrst_low", 0); pop_check(video_reset_n);
    push("ll_busy", 1);     pop_check(busy);
    push("ll_release_cycles", LOCK_TO_RUN);
    wait_for(S_VRST, 1'b1, 300, n); pop_check(n);
    push("ll_cur_mode", 0); pop_check(cur_mode);
    tick();
`ifdef VIDCLK_SWITCH_DONE_EN
    push("ll_done_pulses", 0); pop_check(32'(sd_pulses - sd_before));
    sd_before = sd_pulses;
`endif

    // Request back to 28 MHz while in SETTLE: one RUN cycle, then a fresh BLANK
    video_locked = 1'b0;
    repeat (3) tick();
    video_locked = 1'b1;
    repeat (5) tick();
    req_mode = 1'b1;
    push("rq_release_cycles", LOCK_TO_RUN - 5);
    wait_for(S_VRST, 1'b1, 300, n); pop_check(n);
    push("rq_vidmode_old", 0); pop_check(vidmode);
    tick();
    push("rq_run_one_cycle", 0); pop_check(video_reset_n);
    push("rq_busy", 1);          pop_check(busy);
    push("rq_vidmode_rise_cycles", BLANK);
    wait_for(S_VIDMODE, 1'b1, 300, n); pop_check(n);
    push("rq_final_release_cycles", UNLOCK + 1 + SETTLE);
    wait_for(S_VRST, 1'b1, 300, n); pop_check(n);
    push("rq_cur_mode", 1); pop_check(cur_mode);
    tick();
`ifdef VIDCLK_SWITCH_DONE_EN
    push("rq_done_pulses", 1); pop_check(32'(sd_pulses - sd_before));
    sd_before = sd_pulses;
`endif

    // req_mode bounces inside BLANK: the value at BLANK exit wins
    req_mode = 1'b0;
    repeat (2) tick();
    req_mode = 1'b1;
    repeat (3) tick();
    push("bk_vidmode_at_exit", 1); pop_check(vidmode);
    push("bk_vrst", 0);            pop_check(video_reset_n);
    push("bk_release_cycles", UNLOCK + 1 + SETTLE);
    wait_for(S_VRST, 1'b1, 300, n); pop_check(n);
    push("bk_cur_mode", 1); pop_check(cur_mode);
    tick();
`ifdef VIDCLK_SWITCH_DONE_EN
    push("bk_done_pulses", 0); pop_check(32'(sd_pulses - sd_before));
`endif

    // Reset asserted mid-sequence aborts at once
    req_mode = 1'b0;
    repeat (6) tick();
    push("ab_vidmode_switched", 0); pop_check(vidmode);
    reset_n = 1'b0;
    #1;
    push("ab_vidmode", 1);   pop_check(vidmode);
    push("ab_cur_mode", 1);  pop_check(cur_mode);
    push("ab_busy", 1);      pop_check(busy);
    push("ab_vrst", 0);      pop_check(video_reset_n);
    push("ab_lock_fail", 0); pop_check(lock_fail);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
